// File: rtl/vu_frame_tracker.sv
// vu_frame_tracker: framed N-channel VU level store with per-channel peak hold.
//
// Parses sync-framed byte streams (SYNC_BYTE, then one byte per channel) and
// commits every channel level on the same edge. Each channel keeps a peak value
// that is held for HOLD_TICKS decay ticks and then decays linearly toward the level.
//
// Optional build macro: VU_FRAME_CHECKSUM_EN adds a trailing checksum byte
// (SYNC_BYTE xor all channel bytes) that must match before a frame commits.
//
// Ports:
//   clock        single clock domain
//   reset        asynchronous active-low reset
//   enable       low: no byte accepted, decay frozen, outputs held
//   data_in      received UART byte
//   load         one-cycle strobe, data_in valid
//   error        UART framing error, sampled with load
//   level        committed levels, channel k at [8k+7:8k]
//   peak         peak-hold values, same packing
//   frame_valid  one-cycle pulse on commit
//   frame_err    one-cycle pulse on frame abort

// Per-channel peak-hold / decay lane.
module vu_peak_lane #(
  parameter int HOLD_TICKS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       commit,     // this edge loads new_level into the level store
  input  logic       tick,       // decay tick
  input  logic [7:0] new_level,  // shadow byte that commit would load
  input  logic [7:0] level,      // currently committed level
  output logic [7:0] peak
);
  logic [7:0] hold;
  logic [7:0] cur;

  // Decay compares against the level that is valid after this edge.
  assign cur = commit ? new_level : level;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      peak <= '0;
      hold <= '0;
    end else if (commit && new_level >= peak) begin
      peak <= new_level;
      hold <= 8'(HOLD_TICKS);
    end else if (tick && hold != 8'd0) begin
      hold <= hold - 8'd1;
    end else if (tick && peak > cur) begin
      // peak > cur implies peak > 0, so this cannot wrap
      peak <= peak - 8'd1;
    end
  end
endmodule

module vu_frame_tracker #(
  parameter int         CHANNELS       = 2,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         HOLD_TICKS     = 16,
  parameter int         DECAY_DIV      = 250000,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            data_in,
  input  logic                  load,
  input  logic                  error,
  output logic [8*CHANNELS-1:0] level,
  output logic [8*CHANNELS-1:0] peak,
  output logic                  frame_valid,
  output logic                  frame_err
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = $clog2(DECAY_DIV);
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PLIM = PW'(DECAY_DIV - 1);

`ifdef VU_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, CHECK = 2'd2, COMMIT = 2'd3} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, COMMIT = 2'd3} state_t;
`endif

  state_t                     state;
  logic [IW-1:0]              idx;
  logic [TW-1:0]              tcnt;
  logic [PW-1:0]              pre;
  logic [CHANNELS-1:0][7:0]   shadow;
  logic [CHANNELS-1:0][7:0]   level_q;
  logic [CHANNELS-1:0][7:0]   peak_q;
  logic                       tick;
  logic                       commit;

  assign tick   = enable && (pre == PLIM);
  assign commit = enable && (state == COMMIT);
  assign level  = level_q;
  assign peak   = peak_q;

  // Decay prescaler: wraps at DECAY_DIV-1, frozen while disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      pre <= '0;
    else if (enable) pre <= tick ? '0 : pre + 1'b1;
  end

  // Frame parser. The timeout never exceeds TLIM because reaching it aborts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      tcnt        <= '0;
      shadow      <= '0;
      level_q     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef VU_FRAME_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (enable) begin
        unique case (state)
          IDLE: if (load && !error && data_in == SYNC_BYTE) begin
            state <= DATA;
            idx   <= '0;
            tcnt  <= '0;
`ifdef VU_FRAME_CHECKSUM_EN
            csum  <= SYNC_BYTE;
`endif
          end
          DATA: if (load) begin
            tcnt <= '0;
            if (error) begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end else begin
              shadow[idx] <= data_in;
              idx         <= idx + 1'b1;
`ifdef VU_FRAME_CHECKSUM_EN
              csum        <= csum ^ data_in;
              if (idx == LAST) state <= CHECK;
`else
              if (idx == LAST) state <= COMMIT;
`endif
            end
          end else if (tcnt == TLIM) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`ifdef VU_FRAME_CHECKSUM_EN
          CHECK: if (load) begin
            tcnt <= '0;
            if (!error && data_in == csum) begin
              state <= COMMIT;
            end else begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end
          end else if (tcnt == TLIM) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
          COMMIT: begin
            level_q     <= shadow;
            frame_valid <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    vu_peak_lane #(.HOLD_TICKS(HOLD_TICKS)) u_lane (
      .clock     (clock),
      .reset     (reset),
      .commit    (commit),
      .tick      (tick),
      .new_level (shadow[k]),
      .level     (level_q[k]),
      .peak      (peak_q[k])
    );
  end
endmodule
